axi4_master_seq: RTL

//  Synthesisable, parametrised AXI4 burst master driven by a command port. Writes issue AW and W concurrently, then

---
 rtl/axi4_master_seq.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_master_seq.sv
// axi4_master_seq
//   Command-driven AXI4 burst master. A write command issues AW and the W
//   burst independently and then collects B. A read command issues AR and
//   then collects R, comparing every beat against the incrementing pattern
//   cmd_data + beat. Idle cycles ahead of each W or R beat come from a
//   16-bit LFSR, bounded by cmd_max_wait.
//
// Ports
//   ACLK, ARESET         clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_write            1 = write burst, 0 = read burst
//   cmd_addr/id/len      burst start address, AxID, AxLEN
//   cmd_data             first-beat data; beat n carries cmd_data + n
//   cmd_max_wait         upper bound on idle cycles before each beat
//   done, done_resp      one-cycle completion pulse and worst response
//   err_count            saturating count of read-check errors
//   M_AXI_*              AXI4 master interface (AW, W, B, AR, R channels)
module axi4_master_seq #(
  parameter int unsigned C_ADDR_WIDTH = 32,
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_ID_WIDTH   = 1,
  parameter logic [15:0] C_LFSR_SEED  = 16'hACE1
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_ID_WIDTH-1:0]     cmd_id,
  input  logic [7:0]                cmd_len,
  input  logic [C_DATA_WIDTH-1:0]   cmd_data,
  input  logic [7:0]                cmd_max_wait,
  output logic                      done,
  output logic [1:0]                done_resp,
  output logic [15:0]               err_count,
  output logic [C_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                M_AXI_AWLEN,
  output logic [2:0]                M_AXI_AWSIZE,
  output logic [1:0]                M_AXI_AWBURST,
  output logic [3:0]                M_AXI_AWCACHE,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                      M_AXI_WLAST,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [C_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [C_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                M_AXI_ARLEN,
  output logic [2:0]                M_AXI_ARSIZE,
  output logic [1:0]                M_AXI_ARBURST,
  output logic [3:0]                M_AXI_ARCACHE,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [C_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RLAST,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  localparam logic [2:0] AXSIZE = 3'($clog2(C_DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [C_ADDR_WIDTH-1:0] addr_q;
  logic [C_ID_WIDTH-1:0]   id_q;
  logic [7:0]              len_q;
  logic [C_DATA_WIDTH-1:0] data_q;
  logic [7:0]              max_wait_q;
  logic [8:0]              beat_q;
  logic [7:0]              wait_q;
  logic [15:0]             lfsr_q;
  logic                    aw_valid_q, aw_done_q;
  logic                    w_valid_q, w_done_q;
  logic                    ar_valid_q, r_ready_q;
  logic [1:0]              resp_q;
  logic [15:0]             err_q;

  // RID is not checked; ordering is guaranteed by a single outstanding burst.
  logic unused_rid;
  assign unused_rid = ^M_AXI_RID;

  // Wait length for the next beat: lfsr mod (max_wait+1), or zero.
  function automatic logic [7:0] pick_wait(input logic [15:0] l, input logic [7:0] mw);
    if (mw == 8'd0) return '0;
    return 8'(l % (16'(mw) + 16'd1));
  endfunction

  logic [15:0]             lfsr_step;
  logic [7:0]              wait_next;
  logic [7:0]              wait_first;
  logic                    beat_is_last;
  logic                    aw_fire, w_fire, ar_fire, r_fire;
  logic                    aw_ok, w_ok;
  logic [C_DATA_WIDTH-1:0] beat_data;
  logic                    r_mis, r_last_err;
  logic [16:0]             err_sum;

  // Taps 16,14,13,11 in right-shift (Galois-free Fibonacci) form.
  assign lfsr_step    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign wait_next    = pick_wait(lfsr_q, max_wait_q);
  assign wait_first   = pick_wait(lfsr_q, cmd_max_wait);
  assign beat_is_last = (beat_q == {1'b0, len_q});
  assign beat_data    = data_q + C_DATA_WIDTH'(beat_q);

  assign aw_fire = aw_valid_q & M_AXI_AWREADY;
  assign w_fire  = w_valid_q & M_AXI_WREADY;
  assign ar_fire = ar_valid_q & M_AXI_ARREADY;
  assign r_fire  = r_ready_q & M_AXI_RVALID;

  // Either handshake may complete first, or both in the same cycle.
  assign aw_ok = aw_done_q | aw_fire;
  assign w_ok  = w_done_q | (w_fire & beat_is_last);

  assign r_mis      = (M_AXI_RDATA != beat_data);
  assign r_last_err = (M_AXI_RLAST != beat_is_last);
  assign err_sum    = {1'b0, err_q} + 17'(r_mis) + 17'(r_last_err);

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cmd_valid) state_nxt = cmd_write ? S_WR : S_RD_ADDR;
      S_WR:      if (aw_ok && w_ok) state_nxt = S_WR_RESP;
      S_WR_RESP: if (M_AXI_BVALID) state_nxt = S_DONE;
      S_RD_ADDR: if (ar_fire) state_nxt = S_RD_DATA;
      S_RD_DATA: if (r_fire && M_AXI_RLAST) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q     <= '0;
      id_q       <= '0;
      len_q      <= '0;
      data_q     <= '0;
      max_wait_q <= '0;
      beat_q     <= '0;
      wait_q     <= '0;
      lfsr_q     <= C_LFSR_SEED;
      aw_valid_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_valid_q  <= 1'b0;
      w_done_q   <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      resp_q     <= '0;
      err_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q     <= cmd_addr;
            id_q       <= cmd_id;
            len_q      <= cmd_len;
            data_q     <= cmd_data;
            max_wait_q <= cmd_max_wait;
            beat_q     <= '0;
            resp_q     <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            lfsr_q     <= lfsr_step;
            wait_q     <= wait_first;
            if (cmd_write) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= (wait_first == 8'd0);
            end else begin
              ar_valid_q <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (aw_fire) begin
            aw_valid_q <= 1'b0;
            aw_done_q  <= 1'b1;
          end
          if (w_fire) begin
            if (beat_is_last) begin
              w_valid_q <= 1'b0;
              w_done_q  <= 1'b1;
            end else begin
              beat_q    <= beat_q + 9'd1;
              lfsr_q    <= lfsr_step;
              wait_q    <= wait_next;
              w_valid_q <= (wait_next == 8'd0);
            end
          end else if (!w_valid_q && !w_done_q) begin
            // Count down idle cycles; WVALID rises once the count expires
            // and then holds until its handshake.
            if (wait_q <= 8'd1) w_valid_q <= 1'b1;
            if (wait_q != 8'd0) wait_q <= wait_q - 8'd1;
          end
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID) resp_q <= (M_AXI_BID != id_q) ? 2'b10 : M_AXI_BRESP;
        end
        S_RD_ADDR: begin
          if (ar_fire) begin
            ar_valid_q <= 1'b0;
            if (wait_q == 8'd0) r_ready_q <= 1'b1;
          end
        end
        S_RD_DATA: begin
          if (r_fire) begin
            err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (M_AXI_RRESP > resp_q) resp_q <= M_AXI_RRESP;
            if (M_AXI_RLAST) begin
              r_ready_q <= 1'b0;
            end else begin
              // A slave overrunning len keeps the counter pinned, never wrapping.
              if (beat_q != 9'h1FF) beat_q <= beat_q + 9'd1;
              lfsr_q    <= lfsr_step;
              wait_q    <= wait_next;
              r_ready_q <= (wait_next == 8'd0);
            end
          end else if (!r_ready_q) begin
            if (wait_q <= 8'd1) r_ready_q <= 1'b1;
            if (wait_q != 8'd0) wait_q <= wait_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign done_resp = resp_q;
  assign err_count = err_q;

  assign M_AXI_AWID    = id_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWSIZE  = AXSIZE;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWCACHE = 4'b0010;
  assign M_AXI_AWVALID = aw_valid_q;

  assign M_AXI_WDATA  = w_valid_q ? beat_data : '0;
  assign M_AXI_WSTRB  = w_valid_q ? '1 : '0;
  assign M_AXI_WLAST  = w_valid_q & beat_is_last;
  assign M_AXI_WVALID = w_valid_q;

  assign M_AXI_BREADY = (state == S_WR_RESP);

  assign M_AXI_ARID    = id_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = AXSIZE;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARCACHE = 4'b0010;
  assign M_AXI_ARVALID = ar_valid_q;

  assign M_AXI_RREADY = r_ready_q;

endmodule
